// File: rtl/shift_pkg.sv
// Shared op-code definitions for the pipelined shift/rotate unit.
package shift_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ROL  = 3'd0;
  localparam logic [OP_W-1:0] OP_ROR  = 3'd1;
  localparam logic [OP_W-1:0] OP_SHL  = 3'd2;
  localparam logic [OP_W-1:0] OP_SHR  = 3'd3;
  localparam logic [OP_W-1:0] OP_SHRA = 3'd4;

  // Codes above OP_SHRA are reserved and pass the operand through untouched.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_SHRA;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered barrel stage: shifts/rotates by 2^K when amount bit K is set.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned K     = 0,
  localparam int unsigned AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_adv,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic [AW-1:0]    i_amt,
  input  logic [OP_W-1:0]  i_op,
  input  logic             i_sign,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [AW-1:0]    o_amt,
  output logic [OP_W-1:0]  o_op,
  output logic             o_sign,
  output logic [WIDTH-1:0] o_nxt_data
);

  localparam int unsigned S = 1 << K;

  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_nxt;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [AW-1:0]    r_amt;
  logic [OP_W-1:0]  r_op;
  logic             r_sign;

  assign w_rol = (i_data << S) | (i_data >> (WIDTH - S));
  assign w_ror = (i_data >> S) | (i_data << (WIDTH - S));
  assign w_shl = i_data << S;
  assign w_shr = i_data >> S;
  // Fill uses the sign captured at accept, not this stage's current MSB.
  assign w_sra = i_sign ? (w_shr | ~({WIDTH{1'b1}} >> S)) : w_shr;

  always_comb begin
    w_nxt = i_data;
    if (i_amt[K]) begin
      unique case (i_op)
        OP_ROL:  w_nxt = w_rol;
        OP_ROR:  w_nxt = w_ror;
        OP_SHL:  w_nxt = w_shl;
        OP_SHR:  w_nxt = w_shr;
        OP_SHRA: w_nxt = w_sra;
        default: w_nxt = i_data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_amt   <= '0;
      r_op    <= '0;
      r_sign  <= 1'b0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      r_data  <= w_nxt;
      r_amt   <= i_amt;
      r_op    <= i_op;
      r_sign  <= i_sign;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_amt      = r_amt;
  assign o_op       = r_op;
  assign o_sign     = r_sign;
  assign o_nxt_data = w_nxt;

endmodule

// File: rtl/shift_rotate_pipe.sv
// Pipelined log-depth shift/rotate unit with valid/ready on both sides.
module shift_rotate_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_illegal
);

  logic             w_valid [AW+1];
  logic [WIDTH-1:0] w_data  [AW+1];
  logic [AW-1:0]    w_amt   [AW+1];
  logic [OP_W-1:0]  w_op    [AW+1];
  logic             w_sign  [AW+1];
  logic [WIDTH-1:0] w_nxt   [AW];

  logic             w_adv;
  logic             r_zero;

  // Whole pipe moves in lock-step; only a stalled valid result blocks it.
  assign w_adv    = !w_valid[AW] || out_ready;
  assign in_ready = w_adv;

  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_amt[0]   = in_amt;
  assign w_op[0]    = in_op;
  assign w_sign[0]  = in_data[WIDTH-1];

  for (genvar k = 0; k < AW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .clk        (clk),
      .clr        (clr),
      .i_adv      (w_adv),
      .i_valid    (w_valid[k]),
      .i_data     (w_data[k]),
      .i_amt      (w_amt[k]),
      .i_op       (w_op[k]),
      .i_sign     (w_sign[k]),
      .o_valid    (w_valid[k+1]),
      .o_data     (w_data[k+1]),
      .o_amt      (w_amt[k+1]),
      .o_op       (w_op[k+1]),
      .o_sign     (w_sign[k+1]),
      .o_nxt_data (w_nxt[k])
    );
  end

  // Zero flag registered alongside the final stage's data.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_zero <= 1'b0;
    end else if (w_adv) begin
      r_zero <= (w_nxt[AW-1] == '0);
    end
  end

  assign out_valid   = w_valid[AW];
  assign out_data    = w_data[AW];
  assign out_zero    = r_zero;
  assign out_illegal = w_valid[AW] && !op_legal(w_op[AW]);

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Randomised and directed bench for shift_rotate_pipe (WIDTH=32 and WIDTH=8 instances).
module tb_shift_rotate_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic        ill;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_amt = '0;
  logic [2:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_zero;
  logic        out_illegal;

  logic        v8 = 1'b0;
  logic        rdy8;
  logic [7:0]  d8 = '0;
  logic [2:0]  a8 = '0;
  logic [2:0]  op8 = '0;
  logic        ov8;
  logic [7:0]  od8;
  logic        oz8;
  logic        oi8;

  exp_t        exp_q[$];
  int          pop_cyc[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_lat = 0;
  bit          hold_pend = 1'b0;
  logic [31:0] held = '0;

  always #5 clk = ~clk;

  shift_rotate_pipe #(.WIDTH(32)) u_dut (
    .clk         (clk),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_amt      (in_amt),
    .in_op       (in_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_zero    (out_zero),
    .out_illegal (out_illegal)
  );

  shift_rotate_pipe #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .clr         (clr),
    .in_valid    (v8),
    .in_ready    (rdy8),
    .in_data     (d8),
    .in_amt      (a8),
    .in_op       (op8),
    .out_valid   (ov8),
    .out_ready   (1'b1),
    .out_data    (od8),
    .out_zero    (oz8),
    .out_illegal (oi8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on a w-bit value held in 64 bits.
  function automatic logic [63:0] ref_model(input int w, input int op, input logic [63:0] d,
                                            input int a);
    logic [63:0] m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d = d & m;
    case (op)
      0: return (a == 0) ? d : (((d << a) | (d >> (w - a))) & m);
      1: return (a == 0) ? d : (((d >> a) | (d << (w - a))) & m);
      2: return (d << a) & m;
      3: return d >> a;
      4: return d[w-1] ? ((d >> a) | (m & ~(m >> a))) : (d >> a);
      default: return d;
    endcase
  endfunction

  function automatic exp_t mk(input int op, input logic [31:0] d, input int a);
    logic [63:0] r;
    r = ref_model(32, op, {32'd0, d}, a);
    return '{data: r[31:0], zero: (r[31:0] == 32'd0), ill: (op > 4), t: 0};
  endfunction

  function automatic exp_t fixed(input logic [31:0] d, input logic ill);
    return '{data: d, zero: (d == 32'd0), ill: ill, t: 0};
  endfunction

  // One clock of the 32-bit DUT: drive at negedge, observe 1 time unit later.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] d,
                      input logic [4:0] a, input logic ordy, input exp_t e, output bit acc);
    exp_t e0;
    @(negedge clk);
    in_valid  = v;
    in_op     = op;
    in_data   = d;
    in_amt    = a;
    out_ready = ordy;
    #1;
    if (hold_pend) begin
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_data", {32'd0, out_data}, {32'd0, held});
    end
    check("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        e0 = exp_q.pop_front();
        check("out_data", {32'd0, out_data}, {32'd0, e0.data});
        check("out_zero", {63'd0, out_zero}, {63'd0, e0.zero});
        check("out_illegal", {63'd0, out_illegal}, {63'd0, e0.ill});
        last_lat = cyc - e0.t;
        pop_cyc.push_back(cyc);
      end
    end
    hold_pend = out_valid && !out_ready;
    held      = out_data;
    acc       = v && in_ready;
    if (acc) begin
      e.t = cyc;
      exp_q.push_back(e);
    end
    cyc++;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a,
                      input exp_t e);
    bit acc;
    int n;
    n = 0;
    do begin
      step(1'b1, op, d, a, 1'b1, e, acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) check("send_accept_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step(1'b0, 3'd0, 32'd0, 5'd0, 1'b1, fixed(32'd0, 1'b0), acc);
      n++;
    end
    if (exp_q.size() != 0) check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] d, input logic [2:0] a,
                      input logic [7:0] exp);
    int n;
    @(negedge clk);
    v8 = 1'b1; op8 = op; d8 = d; a8 = a;
    #1;
    check("w8_in_ready", {63'd0, rdy8}, 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      v8 = 1'b0;
      #1;
      n++;
    end while (!ov8 && n < 20);
    check("w8_latency", 64'(n), 64'd3);
    check("w8_data", {56'd0, od8}, {56'd0, exp});
  endtask

  initial begin
    bit acc;
    int tick;
    logic [31:0] bd;

    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_zero", {63'd0, out_zero}, 64'd0);
    check("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed rotates/shifts with latency.
    send(3'd0, 32'h8000_0001, 5'd1, fixed(32'h0000_0003, 1'b0));
    drain();
    check("latency_w32", 64'(last_lat), 64'd5);
    send(3'd1, 32'h8000_0001, 5'd1, fixed(32'hC000_0000, 1'b0));
    send(3'd4, 32'h8000_0000, 5'd31, fixed(32'hFFFF_FFFF, 1'b0));
    send(3'd3, 32'h8000_0000, 5'd31, fixed(32'h0000_0001, 1'b0));
    send(3'd2, 32'h0000_0001, 5'd31, fixed(32'h8000_0000, 1'b0));
    for (int op = 0; op < 5; op++) send(3'(op), 32'h1234_5678, 5'd0, fixed(32'h1234_5678, 1'b0));
    send(3'd2, 32'h0000_0001, 5'd31, fixed(32'h8000_0000, 1'b0));
    send(3'd3, 32'h0000_0001, 5'd1, fixed(32'h0000_0000, 1'b0));
    send(3'd6, 32'hDEAD_BEEF, 5'd5, fixed(32'hDEAD_BEEF, 1'b1));
    send(3'd0, 32'hDEAD_BEEF, 5'd4, fixed(32'hEADB_EEFD, 1'b0));
    drain();

    // Back-to-back burst: results on consecutive cycles.
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      bd = 32'h0101_0000 + 32'(i);
      send(3'd2, bd, 5'd4, mk(2, bd, 4));
    end
    drain();
    check("b2b_count", 64'(pop_cyc.size()), 64'd8);
    for (int i = 1; i < pop_cyc.size(); i++)
      check("b2b_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);

    // Burst with 4-cycle output stall; held inputs must not slip through.
    tick = 0;
    for (int i = 0; i < 12; i++) begin
      bd = 32'hA5A5_0000 + 32'(i);
      do begin
        step(1'b1, 3'd1, bd, 5'd3, !(tick >= 8 && tick < 12), mk(1, bd, 3), acc);
        tick++;
      end while (!acc && tick < 60);
    end
    drain();

    // Asynchronous clear with results in flight and one stalled at the output.
    for (int i = 0; i < 5; i++) begin
      bd = 32'h0F0F_0000 + 32'(i);
      step(1'b1, 3'd0, bd, 5'd2, 1'b0, mk(0, bd, 2), acc);
    end
    step(1'b0, 3'd0, 32'd0, 5'd0, 1'b0, fixed(32'd0, 1'b0), acc);
    check("pre_clr_stalled", {63'd0, out_valid}, 64'd1);
    #2 clr = 1'b1;
    #1;
    check("clr_async_valid", {63'd0, out_valid}, 64'd0);
    check("clr_async_data", {32'd0, out_data}, 64'd0);
    check("clr_async_illegal", {63'd0, out_illegal}, 64'd0);
    @(negedge clk);
    clr = 1'b0;
    exp_q.delete();
    hold_pend = 1'b0;
    #1;
    check("clr_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 32'd0, 5'd0, 1'b1, fixed(32'd0, 1'b0), acc);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [2:0]  rop;
      logic [31:0] rd;
      logic [4:0]  ra;
      rop = 3'($urandom_range(0, 7));
      rd  = (i % 7 == 0) ? 32'd0 : $urandom;
      ra  = 5'($urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, rop, rd, ra, $urandom_range(0, 3) != 0,
           mk(int'(rop), rd, int'(ra)), acc);
    end
    drain();

    // WIDTH=8 instance.
    run8(3'd0, 8'h81, 3'd1, 8'h03);
    run8(3'd1, 8'h81, 3'd1, 8'hC0);
    run8(3'd4, 8'h80, 3'd7, 8'hFF);
    run8(3'd2, 8'h01, 3'd7, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
